// File: rtl/req_upload_arbiter.sv
// Packet-level round-robin arbiter that shares the request FIFO between the mem,
// icache and dcache upload engines; one packet owns the FIFO from head to tail.
module req_upload_arbiter #(
    parameter int FLIT_W        = 16,
    parameter int MAX_PKT_FLITS = 11,
    parameter int PKT_CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            v_flit_in,
    input  logic [3*FLIT_W-1:0]   flit_in,
    input  logic [5:0]            ctrl_in,
    output logic [2:0]            rdy_out,
    input  logic                  req_fifo_rdy_in,
    output logic                  v_flit_out,
    output logic [FLIT_W-1:0]     flit_out,
    output logic [1:0]            ctrl_out,
    output logic [2:0]            grant_out,
    output logic                  fsm_state,
    output logic                  err_proto,
    output logic [PKT_CNT_W-1:0]  pkt_cnt
);
    localparam logic [1:0]           CTRL_HEAD = 2'b01;
    localparam logic [1:0]           CTRL_BODY = 2'b10;
    localparam logic [1:0]           CTRL_TAIL = 2'b11;
    localparam logic [3:0]           CNT_MAX   = 4'(MAX_PKT_FLITS);
    localparam logic [PKT_CNT_W-1:0] PKT_ONE   = PKT_CNT_W'(1);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [1:0]           r_rrPtr;
    logic [1:0]           r_owner;
    logic [3:0]           r_flitCnt;
    logic                 r_errProto;
    logic [PKT_CNT_W-1:0] r_pktCnt;

    logic [2:0] w_eligible;
    logic [3:0] w_eligible4;
    logic [2:0] w_badIdle;
    logic       w_idleSelValid;
    logic [1:0] w_idleSel;
    logic       w_selValid;
    logic [1:0] w_sel;
    logic       w_xfer;
    logic [3:0] w_flitCntInc;

    function automatic logic [1:0] incMod3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // ctrl bit 0 separates packet openers (01, 11) from body/none (10, 00).
    always_comb begin
        w_eligible = '0;
        w_badIdle  = '0;
        for (int i = 0; i < 3; i++) begin
            w_eligible[i] = v_flit_in[i] & ctrl_in[2*i];
            w_badIdle[i]  = v_flit_in[i] & ~ctrl_in[2*i];
        end
    end

    assign w_eligible4 = {1'b0, w_eligible};

    always_comb begin : rr_scan
        logic [1:0] idx;
        w_idleSelValid = 1'b0;
        w_idleSel      = 2'd0;
        idx            = r_rrPtr;
        for (int k = 0; k < 3; k++) begin
            if (!w_idleSelValid && w_eligible4[idx]) begin
                w_idleSelValid = 1'b1;
                w_idleSel      = idx;
            end
            idx = incMod3(idx);
        end
    end

    always_comb begin
        if (r_state == LOCKED) begin
            w_selValid = 1'b1;
            w_sel      = r_owner;
        end else begin
            w_selValid = w_idleSelValid;
            w_sel      = w_idleSel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_xfer && ctrl_out == CTRL_HEAD) w_nextState = LOCKED;
            LOCKED:  if (w_xfer && ctrl_out == CTRL_TAIL) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Zero-latency mux: the selected requester sees the FIFO ready, everyone else is stalled.
    always_comb begin
        flit_out   = '0;
        ctrl_out   = 2'b00;
        v_flit_out = 1'b0;
        rdy_out    = '0;
        grant_out  = '0;
        fsm_state  = r_state;
        if (w_selValid) begin
            case (w_sel)
                2'd0: begin
                    flit_out     = flit_in[0 +: FLIT_W];
                    ctrl_out     = ctrl_in[1:0];
                    v_flit_out   = v_flit_in[0];
                    rdy_out[0]   = req_fifo_rdy_in;
                    grant_out[0] = 1'b1;
                end
                2'd1: begin
                    flit_out     = flit_in[FLIT_W +: FLIT_W];
                    ctrl_out     = ctrl_in[3:2];
                    v_flit_out   = v_flit_in[1];
                    rdy_out[1]   = req_fifo_rdy_in;
                    grant_out[1] = 1'b1;
                end
                default: begin
                    flit_out     = flit_in[2*FLIT_W +: FLIT_W];
                    ctrl_out     = ctrl_in[5:4];
                    v_flit_out   = v_flit_in[2];
                    rdy_out[2]   = req_fifo_rdy_in;
                    grant_out[2] = 1'b1;
                end
            endcase
        end
    end

    assign w_xfer       = v_flit_out & req_fifo_rdy_in;
    assign w_flitCntInc = (r_flitCnt == 4'hF) ? 4'hF : r_flitCnt + 4'd1;

    // Over-long packets keep their lock; only the error flag records the violation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rrPtr    <= 2'd0;
            r_owner    <= 2'd0;
            r_flitCnt  <= 4'd0;
            r_errProto <= 1'b0;
            r_pktCnt   <= '0;
        end else if (r_state == IDLE) begin
            if (|w_badIdle) begin
                r_errProto <= 1'b1;
            end
            if (w_xfer) begin
                if (ctrl_out == CTRL_HEAD) begin
                    r_owner   <= w_sel;
                    r_flitCnt <= 4'd1;
                end else begin
                    r_rrPtr  <= incMod3(w_sel);
                    r_pktCnt <= r_pktCnt + PKT_ONE;
                end
            end
        end else if (w_xfer) begin
            if (w_flitCntInc > CNT_MAX) begin
                r_errProto <= 1'b1;
            end
            if (ctrl_out == CTRL_TAIL) begin
                r_rrPtr   <= incMod3(r_owner);
                r_pktCnt  <= r_pktCnt + PKT_ONE;
                r_flitCnt <= 4'd0;
            end else begin
                r_flitCnt <= w_flitCntInc;
                if (ctrl_out != CTRL_BODY) begin
                    r_errProto <= 1'b1;
                end
            end
        end
    end

    assign err_proto = r_errProto;
    assign pkt_cnt   = r_pktCnt;

endmodule

// File: doc/req_upload_arbiter.md
Name: req_upload_arbiter

Overview:
- Packet-level round-robin arbiter that shares one outgoing request FIFO between three request-upload engines: memory request, I-cache request and D-cache request uploaders.
- Each uploader emits 16-bit flits tagged with a 2-bit ctrl code.
- The arbiter locks the FIFO to one uploader from head flit to tail flit, so packets never interleave.
- Sits between the upload FSM/datapath pairs and the req FIFO in the communication assist.

Parameters:
FLIT_W, 16, flit width in bits
MAX_PKT_FLITS, 11, maximum legal flits per packet (head + addrhi + addrlo + 8 data)
PKT_CNT_W, 8, width of the forwarded-packet statistics counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
v_flit_in  input  3  per-requester flit valid, bit i = requester i (0 = mem, 1 = icache, 2 = dcache)
flit_in  input  3*FLIT_W  requester i flit on bits [i*FLIT_W +: FLIT_W]
ctrl_in  input  6  requester i ctrl on bits [2i+1:2i]; 01 = head, 10 = body, 11 = tail or single-flit, 00 = none
rdy_out  output  3  per-requester ready; a flit transfers when v_flit_in[i] & rdy_out[i]
req_fifo_rdy_in  input  1  req FIFO can accept a flit this cycle
v_flit_out  output  1  flit valid to req FIFO
flit_out  output  FLIT_W  flit to req FIFO
ctrl_out  output  2  ctrl of flit_out
grant_out  output  3  one-hot current owner; all zero when none
fsm_state  output  1  0 = IDLE, 1 = LOCKED
err_proto  output  1  sticky protocol-error flag
pkt_cnt  output  PKT_CNT_W  count of completed packets (tail transfers), wraps

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: fsm_state = IDLE, rr_ptr = 0, owner = none, grant_out = 0, flit_cnt = 0, err_proto = 0, pkt_cnt = 0. Combinational outputs follow from these: v_flit_out = 0, rdy_out = 0, flit_out = 0, ctrl_out = 00.
- Datapath is combinational with zero latency: flit_out/ctrl_out = the selected requester's flit/ctrl. v_flit_out = selected requester's valid. rdy_out[sel] = req_fifo_rdy_in; all other rdy_out bits = 0. "Transfer" below means v_flit_out & req_fifo_rdy_in.
- When nothing is selected: flit_out = 0, ctrl_out = 00, v_flit_out = 0.
- IDLE state:
  - Eligible requesters: v_flit_in[i] = 1 and ctrl_in[i] ∈ {01, 11}.
  - Selection: the first eligible requester in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). grant_out shows this combinational selection.
  - Any requester presenting v = 1 with ctrl 10 or 00 while IDLE sets err_proto. That requester is not eligible and its rdy stays 0.
  - Transfer of ctrl 01 → LOCKED next cycle; owner = sel, flit_cnt = 1.
  - Transfer of ctrl 11 (single-flit packet) → remain IDLE; rr_ptr = sel + 1 mod 3; pkt_cnt + 1.
  - No transfer → no state change. The selection may change next cycle; no grant is held without a transfer.
- LOCKED state:
  - Only the owner is selected; grant_out = owner one-hot, regardless of owner's valid.
  - Other requesters are blocked (rdy = 0) even if they are valid.
  - Each transfer increments flit_cnt (saturating at 15).
  - Transfer of ctrl 11 → IDLE next cycle; rr_ptr = owner + 1 mod 3; pkt_cnt + 1; flit_cnt = 0.
  - Transfer of ctrl 01 or 00 while LOCKED → err_proto set; the flit is still forwarded as a body flit (ctrl_out passes through unchanged).
  - Transfer that makes flit_cnt exceed MAX_PKT_FLITS without a tail → err_proto set; the lock is held until tail.
- Wrap-around: rr_ptr cycles 0 → 1 → 2 → 0. pkt_cnt wraps from 2^PKT_CNT_W − 1 to 0.
- Backpressure: while req_fifo_rdy_in = 0, nothing transfers and no state changes. Requesters must hold flit and ctrl stable while valid and not ready.
- Simultaneous events:
  - Tail transfer and new heads from others in the same cycle: the tail completes; new selection starts the next cycle from the updated rr_ptr.
  - A requester's tail may be followed immediately by its own head next cycle only if no other requester is eligible.
- err_proto is cleared only by rst.
- Reset mid-packet: the lock is dropped immediately. Uploaders are reset by the same rst, so no partial packet resumes.

Test Plan:
- Single requester: mem sends 3-flit packet 01/10/11 (0x1234, 0xAAAA, 0x5555) with fifo always ready → three consecutive v_flit_out cycles, ctrl_out 01, 10, 11; pkt_cnt = 1; rr_ptr = 1; fsm_state back to 0.
- All three requesters post heads simultaneously after reset → grant order across packets is 0, 1, 2; no interleaving (grant_out constant from head to tail); pkt_cnt = 3.
- Requester 1 locked, requester 2 asserts head mid-packet → rdy_out[2] = 0 until the cycle after requester 1's tail; then requester 2 is granted.
- Toggle req_fifo_rdy_in 1/0 every cycle during an 11-flit packet → exactly 11 transfers, flit order preserved, no error.
- Body flit (ctrl 10) from requester 0 while IDLE → err_proto = 1, rdy_out[0] = 0, no output; a 12-flit packet → err_proto = 1 on the 12th transfer.
- Assert rst after the head and 2 body flits have transferred → next cycle fsm_state = 0, grant_out = 0, pkt_cnt = 0, err_proto = 0, rr_ptr = 0.
